// File: rtl/keypad_4x4_scanner.sv
`default_nettype none
// ============================================================================
// keypad_4x4_scanner : 4x4 matrix keypad row scanner with whole-scan debounce
// Rev 1.0 - initial release
// ============================================================================
module keypad_4x4_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    K_NONE   = 2'd0,
    K_SINGLE = 2'd1,
    K_MULTI  = 2'd2
  } kind_t;

  // code is forced to zero unless kind is K_SINGLE, so whole-struct compares work
  typedef struct packed {
    kind_t      kind;
    logic [3:0] code;
  } scan_t;

  logic [3:0]       col_s1, col_s2;
  logic [DIV_W-1:0] div;
  logic [1:0]       row;
  logic [1:0]       row_next;
  logic [11:0]      snapshot;
  logic [15:0]      snap_full;
  logic [4:0]       ones;
  logic [3:0]       idx;
  scan_t            result, cand, stable, last_nm;
  logic [CNT_W-1:0] count, next_count;
  logic             accept;

  function automatic logic [3:0] key_map(input logic [3:0] pos);
    case (pos)
      4'd0:  key_map = 4'h1;
      4'd1:  key_map = 4'h2;
      4'd2:  key_map = 4'h3;
      4'd3:  key_map = 4'hA;
      4'd4:  key_map = 4'h4;
      4'd5:  key_map = 4'h5;
      4'd6:  key_map = 4'h6;
      4'd7:  key_map = 4'hB;
      4'd8:  key_map = 4'h7;
      4'd9:  key_map = 4'h8;
      4'd10: key_map = 4'h9;
      4'd11: key_map = 4'hC;
      4'd12: key_map = 4'hE;
      4'd13: key_map = 4'h0;
      4'd14: key_map = 4'hF;
      default: key_map = 4'hD;
    endcase
  endfunction

  assign row_next  = row + 2'd1;
  // Row 3 is classified on its own sample cycle, so its bits come straight from the synchronizer
  assign snap_full = {~col_s2, snapshot};

  always_comb begin
    ones = 5'd0;
    idx  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap_full[i]) begin
        ones = ones + 5'd1;
        idx  = 4'(i);
      end
    end
    result.kind = K_NONE;
    result.code = 4'h0;
    if (ones == 5'd1) begin
      result.kind = K_SINGLE;
      result.code = key_map(idx);
    end else if (ones != 5'd0) begin
      result.kind = K_MULTI;
    end
  end

  always_comb begin
    next_count = CNT_W'(1);
    if (result == cand)
      next_count = (count == CNT_MAX) ? CNT_MAX : count + CNT_W'(1);
    accept = (next_count == CNT_MAX) && (result != stable);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_s1       <= 4'b1111;
      col_s2       <= 4'b1111;
      div          <= '0;
      row          <= 2'd0;
      row_out      <= 4'b1110;
      snapshot     <= '0;
      cand.kind    <= K_NONE;
      cand.code    <= 4'h0;
      stable.kind  <= K_NONE;
      stable.code  <= 4'h0;
      last_nm.kind <= K_NONE;
      last_nm.code <= 4'h0;
      count        <= '0;
      key_valid    <= 1'b0;
      key_code     <= 4'h0;
      key_down     <= 1'b0;
    end else begin
      col_s1    <= col_in;
      col_s2    <= col_s1;
      key_valid <= 1'b0;
      if (div == DIV_LAST) begin
        div     <= '0;
        row     <= row_next;
        row_out <= ~(4'b0001 << row_next);
        case (row)
          2'd0: snapshot[3:0]  <= ~col_s2;
          2'd1: snapshot[7:4]  <= ~col_s2;
          2'd2: snapshot[11:8] <= ~col_s2;
          default: begin
            cand  <= result;
            count <= next_count;
            if (accept) begin
              stable <= result;
              case (result.kind)
                K_SINGLE: begin
                  key_down <= 1'b1;
                  // Recovering from a multi-key scan with the same key still down is not a new press
                  if (last_nm != result) begin
                    key_code  <= result.code;
                    key_valid <= 1'b1;
                  end
                  last_nm <= result;
                end
                K_NONE: begin
                  key_down <= 1'b0;
                  last_nm  <= result;
                end
                default: ;
              endcase
            end
          end
        endcase
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_4x4_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_4x4_scanner : vector table + pulse scoreboard bench for the scanner
// Rev 1.0 - initial release
// ============================================================================
module tb_keypad_4x4_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_down;

  logic [15:0] keys = 16'h0000;
  logic        bounce_en = 1'b0;
  logic [3:0]  bounce_val = 4'hF;
  logic [3:0]  col_m;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  logic mon_en = 1'b0;
  logic prev_kv = 1'b0;
  logic [31:0] tcnt = 32'd0;
  logic [3:0] exp_row;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [15:0] keys;
    int          scans;
    logic        exp_down;
    logic [3:0]  exp_code;
    int          exp_pulses;
  } vec_t;
  vec_t vecs[15];

  keypad_4x4_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row_out),
    .key_valid(key_valid), .key_code(key_code), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Passive keypad: a closed switch pulls its column low while its row is driven low
  always_comb begin
    col_m = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row_out[r] == 1'b0 && keys[4*r+c]) col_m[c] = 1'b0;
  end
  assign col_in = bounce_en ? bounce_val : col_m;

  always @(posedge clk) begin
    if (!rst_n) tcnt <= 32'd0;
    else        tcnt <= tcnt + 32'd1;
  end
  assign exp_row = ~(4'b0001 << tcnt[3:2]);

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("row_out", 32'(row_out), 32'(exp_row));
      if (key_valid) begin
        chk("kv_width", 32'(prev_kv), 0);
        pulse_cnt++;
        if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
        else chk("pulse_code", 32'(key_code), 32'(exp_q.pop_front()));
      end
      prev_kv = key_valid;
    end
  end

  task automatic run_scans(input int n);
    repeat (n * SCAN_CYC) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int p0;
    vecs[0]  = '{16'h0000, 2, 1'b0, 4'h0, 0};
    vecs[1]  = '{16'h0040, 3, 1'b1, 4'h6, 1};
    vecs[2]  = '{16'h0000, 2, 1'b1, 4'h6, 0};
    vecs[3]  = '{16'h0000, 1, 1'b0, 4'h6, 0};
    vecs[4]  = '{16'h4000, 2, 1'b0, 4'h6, 0};
    vecs[5]  = '{16'h0000, 1, 1'b0, 4'h6, 0};
    vecs[6]  = '{16'h4000, 2, 1'b0, 4'h6, 0};
    vecs[7]  = '{16'h4000, 1, 1'b1, 4'hF, 1};
    vecs[8]  = '{16'h0000, 3, 1'b0, 4'hF, 0};
    vecs[9]  = '{16'h0001, 3, 1'b1, 4'h1, 1};
    vecs[10] = '{16'h0801, 4, 1'b1, 4'h1, 0};
    vecs[11] = '{16'h0001, 3, 1'b1, 4'h1, 0};
    vecs[12] = '{16'h0800, 3, 1'b1, 4'hC, 1};
    vecs[13] = '{16'h0000, 3, 1'b0, 4'hC, 0};
    vecs[14] = '{16'h2000, 3, 1'b1, 4'h0, 1};

    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("rst_row_out", 32'(row_out), 32'hE);
    chk("rst_key_valid", 32'(key_valid), 0);
    chk("rst_key_code", 32'(key_code), 0);
    chk("rst_key_down", 32'(key_down), 0);
    rst_n = 1'b1;

    for (int v = 0; v < 15; v++) begin
      keys = vecs[v].keys;
      if (vecs[v].exp_pulses != 0) exp_q.push_back(vecs[v].exp_code);
      p0 = pulse_cnt;
      run_scans(vecs[v].scans);
      chk($sformatf("v%0d_key_down", v), 32'(key_down), 32'(vecs[v].exp_down));
      chk($sformatf("v%0d_key_code", v), 32'(key_code), 32'(vecs[v].exp_code));
      chk($sformatf("v%0d_pulses", v), 32'(pulse_cnt - p0), 32'(vecs[v].exp_pulses));
    end

    // Mid-scan reset with key (3,1) still held
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_key_down", 32'(key_down), 0);
    chk("midrst_row_out", 32'(row_out), 32'hE);
    chk("midrst_key_valid", 32'(key_valid), 0);
    rst_n = 1'b1;
    exp_q.push_back(4'h0);
    p0 = pulse_cnt;
    run_scans(2);
    chk("postrst_early_pulses", 32'(pulse_cnt - p0), 0);
    chk("postrst_early_down", 32'(key_down), 0);
    run_scans(1);
    chk("postrst_pulses", 32'(pulse_cnt - p0), 1);
    chk("postrst_key_down", 32'(key_down), 1);
    chk("postrst_key_code", 32'(key_code), 0);

    // Per-cycle bounce for two scans, then a clean (2,0)
    p0 = pulse_cnt;
    bounce_en = 1'b1;
    bounce_val = 4'($urandom(32'd12345));
    repeat (2 * SCAN_CYC) begin
      @(posedge clk);
      #1;
      bounce_val = 4'($urandom);
    end
    keys = 16'h0100;
    bounce_en = 1'b0;
    exp_q.push_back(4'h7);
    repeat (4 * SCAN_CYC) @(posedge clk);
    @(negedge clk);
    #1;
    chk("bounce_pulses", 32'(pulse_cnt - p0), 1);
    chk("bounce_key_code", 32'(key_code), 32'h7);
    chk("bounce_key_down", 32'(key_down), 1);

    chk("pending_pulses", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_4x4_scanner.md
Name: keypad_4x4_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver.
- Scans a 4x4 matrix keypad by driving one active-low row at a time and sampling the active-low columns.
- Debounces the result over whole scans and reports each new key press as a 4-bit hex code with a 1-cycle strobe.
- Sits between the board keypad pins and the CPU/IO logic; its key_code can feed the display data inputs directly.

Parameters:
- SCAN_DIV, 50000: clk cycles each row stays active (1 ms at 50 MHz). Must be >= 4.
- DEBOUNCE_SCANS, 20: consecutive identical full-scan results required before the result is accepted. Must be >= 1.

Ports:
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  reset, synchronous, active-low
- col_in  input  4  keypad columns, active-low (pulled up); col_in[c] is column c; asynchronous to clk
- row_out  output  4  row drive, active-low one-hot; row_out[r] is row r
- key_valid  output  1  1-cycle pulse: new debounced press, key_code valid
- key_code  output  4  hex code of the last accepted key; held until the next press
- key_down  output  1  level: the accepted key is still held

Behaviour:
- Reset state (applied on posedge clk while rst_n=0):
  - row_out=4'b1110, row index=0, divider=0.
  - key_valid=0, key_code=4'h0, key_down=0.
  - Synchronizer flops=4'b1111, candidate=NONE, stable=NONE, count=0.
- Reset mid-scan or mid-debounce discards all state. A key held through reset needs a full fresh debounce and yields a new key_valid.
- Input synchronization: col_in passes through 2 flops (col_s) before any use.
- Row sequencing:
  - Divider counts 0..SCAN_DIV-1 per row. At SCAN_DIV-1 it wraps to 0 and the row advances 0->1->2->3->0.
  - row_out = ~(1<<row).
  - One full scan = 4*SCAN_DIV cycles.
- Sampling:
  - On the divider=SCAN_DIV-1 cycle of row r, store ~col_s into snapshot bits [4r+3:4r].
  - The 2-flop delay is covered because SCAN_DIV>=4.
- Key map, code at (row, col):
  - Row 0: (0,0)=1, (0,1)=2, (0,2)=3, (0,3)=A
  - Row 1: (1,0)=4, (1,1)=5, (1,2)=6, (1,3)=B
  - Row 2: (2,0)=7, (2,1)=8, (2,2)=9, (2,3)=C
  - Row 3: (3,0)=E (*), (3,1)=0, (3,2)=F (#), (3,3)=D
- Scan classification, evaluated on the row-3 sample cycle using the completed snapshot including row 3:
  - 0 bits set -> NONE
  - exactly 1 bit set -> SINGLE(code)
  - 2 or more bits set -> MULTI
- Debounce, applied at each evaluation:
  - If result == candidate: count = min(count+1, DEBOUNCE_SCANS).
  - Otherwise: candidate=result, count=1.
  - When count reaches DEBOUNCE_SCANS and candidate != stable: stable <= candidate, and the acceptance actions below fire.
- Acceptance actions; outputs update on the same edge, visible the cycle after the evaluation cycle:
  - New stable SINGLE(c), and the last non-MULTI stable state was not SINGLE(c):
    - key_code<=c, key_down<=1, key_valid<=1 for exactly 1 cycle.
  - New stable SINGLE(c), and the last non-MULTI stable state was SINGLE(c) (recovery from MULTI while still holding c):
    - key_down<=1, no pulse.
  - New stable NONE: key_down<=0, key_code unchanged, no pulse.
  - New stable MULTI: outputs unchanged, no pulse (ghosting/rollover ignored).
  - Direct SINGLE(a) -> SINGLE(b), a != b: pulse with code b.
- Latency:
  - A clean press that is present at all four row samples of scan k is accepted at the evaluation of scan k+DEBOUNCE_SCANS-1.
  - key_valid rises 1 cycle after that evaluation.
- Bounce shorter than DEBOUNCE_SCANS scans never changes outputs.
- key_valid is never asserted on two consecutive cycles.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3; 1 scan = 16 cycles):
- Reset held 5 cycles, then released with no keys pressed -> row_out sequences 1110,1101,1011,0111 every 4 cycles; key_valid=0, key_down=0, key_code=0 throughout.
- Keypad model closes (row1,col2) from before scan 0 onward -> exactly one key_valid pulse after the 3rd scan evaluation, key_code=6, key_down=1. Release -> key_down=0 after 3 NONE scans, key_code stays 6, no pulse.
- (3,2) closed for 2 scans, open 1, closed 2 -> no key_valid, key_down=0. Then held continuously 3 scans -> pulse with key_code=F.
- Hold (0,0) until accepted (code 1); add (2,3) for 4 scans (MULTI); remove it -> key_down stays 1 throughout, no second pulse. Then release (0,0) and press (2,3) directly with no NONE scans between -> pulse with key_code=C.
- Hold (3,1) until key_down=1, code 0. Assert rst_n=0 for 1 cycle mid-scan -> next cycle key_down=0, row_out=1110. Key still held -> new pulse after 3 scans, key_code=0.
- Random col_in toggling every cycle (bounce faster than the row period) for 2 scans, then stable (2,0) -> key_valid is only ever 1 cycle wide and at most one pulse occurs, with key_code=7.
